// File: rtl/rr_arb8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: state encoding,
// requester count and grant-index width.
package rr_arb8_pkg;
  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requester bank (master) and the arbiter (slave).
interface rr_arb8_if;
  logic                             en;
  logic [rr_arb8_pkg::NUM_REQ-1:0]  req;
  logic [rr_arb8_pkg::NUM_REQ-1:0]  gnt;
  logic [rr_arb8_pkg::ID_W-1:0]     gnt_id;
  logic                             gnt_vld;
  logic                             timeout;

  modport master (output en, req, input gnt, gnt_id, gnt_vld, timeout);
  modport slave  (input en, req, output gnt, gnt_id, gnt_vld, timeout);
endinterface

// File: rtl/rr_arb8_onehot_dec3to8.sv
// Combinational 3:8 one-hot decoder with enable; all zeros when disabled.
module onehot_dec3to8 (
  input  logic [2:0] i_sel,
  input  logic       i_en,
  output logic [7:0] o_dec
);
  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign o_dec[gi] = i_en && (i_sel == 3'(gi));
  end
endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, rotating
// priority pointer and a per-tenure hold limit of MAX_HOLD cycles.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arb8_if.slave   bus
);
  state_t            r_state, w_state_next;
  logic [ID_W-1:0]   r_ptr, w_ptr_next;
  logic [7:0]        r_hold_cnt, w_hold_next;
  logic [ID_W-1:0]   r_gnt_id, w_id_next;
  logic              r_gnt_vld, w_vld_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic              r_timeout, w_timeout_next;

  logic [3:0]        w_arb_idle, w_arb_hand;
  logic              w_at_limit, w_release;

  // Rotate so the start point sits at bit 0, take the lowest set bit, then
  // rotate the index back. Result is {found, index}.
  function automatic logic [3:0] arb_search(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0] start);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      pe;
    logic                 found;
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_REQ-1:0];
    pe    = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pe    = ID_W'(i);
        found = 1'b1;
      end
    end
    return {found, pe + start};
  endfunction

  assign w_arb_idle = arb_search(bus.req, r_ptr);
  assign w_arb_hand = arb_search(bus.req, r_gnt_id + 3'd1);
  assign w_at_limit = (r_hold_cnt == 8'(MAX_HOLD - 1));
  assign w_release  = !bus.req[r_gnt_id] || w_at_limit || !bus.en;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_hold_next    = r_hold_cnt;
    w_id_next      = r_gnt_id;
    w_vld_next     = 1'b0;
    w_timeout_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.en && (bus.req != '0)) begin
          w_state_next = GRANT;
          w_id_next    = w_arb_idle[ID_W-1:0];
          w_vld_next   = 1'b1;
          w_hold_next  = 8'd0;
        end
      end
      GRANT: begin
        if (!w_release) begin
          w_hold_next = r_hold_cnt + 8'd1;
          w_vld_next  = 1'b1;
        end else begin
          w_ptr_next = r_gnt_id + 3'd1;
          if (!bus.en) begin
            w_state_next = IDLE;
          end else begin
            // A holder that dropped its request on the last cycle is not a timeout.
            w_timeout_next = w_at_limit && bus.req[r_gnt_id];
            if (w_arb_hand[ID_W]) begin
              w_id_next   = w_arb_hand[ID_W-1:0];
              w_vld_next  = 1'b1;
              w_hold_next = 8'd0;
            end else begin
              w_state_next = IDLE;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  onehot_dec3to8 u_dec (
    .i_sel (w_id_next),
    .i_en  (w_vld_next),
    .o_dec (w_gnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= 8'd0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
      r_gnt      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_hold_cnt <= w_hold_next;
      r_gnt_id   <= w_id_next;
      r_gnt_vld  <= w_vld_next;
      r_gnt      <= w_gnt_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_rr_arb8.sv
// Drives four arbiters (MAX_HOLD = 1, 2, 4, 8) with shared stimulus and compares
// every output each cycle against a tenure-level reference model.
module tb_rr_arb8;
  logic       clk;
  logic       rst_n;
  logic [7:0] req_drv;
  logic       en_drv;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  rr_arb8_if if1 ();
  rr_arb8_if if2 ();
  rr_arb8_if if4 ();
  rr_arb8_if if8 ();

  assign if1.req = req_drv;  assign if1.en = en_drv;
  assign if2.req = req_drv;  assign if2.en = en_drv;
  assign if4.req = req_drv;  assign if4.en = en_drv;
  assign if8.req = req_drv;  assign if8.en = en_drv;

  rr_arb8 #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  rr_arb8 #(.MAX_HOLD(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  rr_arb8 #(.MAX_HOLD(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  rr_arb8 #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, one slot per DUT: holder, tenure length so far, next search start.
  int mh     [4] = '{1, 2, 4, 8};
  bit m_busy [4];
  int m_id   [4];
  int m_len  [4];
  int m_ptr  [4];
  bit m_to   [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, n_cycle, obs, exp);
    end
  endtask

  function automatic int find_winner(input logic [7:0] r, input int start);
    for (int j = 0; j < 8; j++) begin
      int c = (start + j) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_busy[k] = 0; m_id[k] = 0; m_len[k] = 0; m_ptr[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      bit to_new = 0;
      if (!m_busy[k]) begin
        if (en_drv && req_drv != 8'h00) begin
          m_id[k] = find_winner(req_drv, m_ptr[k]);
          m_busy[k] = 1;
          m_len[k] = 1;
        end
      end else begin
        bit still = req_drv[m_id[k]];
        bit full  = (m_len[k] == mh[k]);
        if (en_drv && still && !full) begin
          m_len[k]++;
        end else begin
          int w;
          m_ptr[k] = (m_id[k] + 1) % 8;
          if (!en_drv) begin
            m_busy[k] = 0;
          end else begin
            to_new = still && full;
            w = find_winner(req_drv, m_ptr[k]);
            if (w >= 0) begin
              m_id[k] = w;
              m_len[k] = 1;
            end else begin
              m_busy[k] = 0;
            end
          end
        end
      end
      m_to[k] = to_new;
    end
  endtask

  task automatic check_one(input int k, input logic [7:0] g, input logic [2:0] id,
                           input logic vld, input logic to);
    logic [7:0] exp_g;
    exp_g = m_busy[k] ? (8'd1 << m_id[k]) : 8'h00;
    check($sformatf("mh%0d gnt", mh[k]), 32'(g), 32'(exp_g));
    check($sformatf("mh%0d gnt_id", mh[k]), 32'(id), 32'(m_id[k]));
    check($sformatf("mh%0d gnt_vld", mh[k]), 32'(vld), 32'(m_busy[k]));
    check($sformatf("mh%0d timeout", mh[k]), 32'(to), 32'(m_to[k]));
  endtask

  task automatic check_all();
    check_one(0, if1.gnt, if1.gnt_id, if1.gnt_vld, if1.timeout);
    check_one(1, if2.gnt, if2.gnt_id, if2.gnt_vld, if2.timeout);
    check_one(2, if4.gnt, if4.gnt_id, if4.gnt_vld, if4.timeout);
    check_one(3, if8.gnt, if8.gnt_id, if8.gnt_vld, if8.timeout);
  endtask

  // One transaction: drive at negedge, model the edge, check at the next negedge.
  task automatic drive(input logic [7:0] r, input logic e);
    req_drv = r;
    en_drv  = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    n_cycle++;
    check_all();
    $display("cyc %0d en=%0b req=%02h | gnt1=%02h gnt2=%02h gnt4=%02h gnt8=%02h to=%0b%0b%0b%0b",
             n_cycle, e, r, if1.gnt, if2.gnt, if4.gnt, if8.gnt,
             if1.timeout, if2.timeout, if4.timeout, if8.timeout);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " gnt"},     32'(if8.gnt),     32'h00);
    check({tag, " gnt_id"},  32'(if8.gnt_id),  32'h0);
    check({tag, " gnt_vld"}, 32'(if8.gnt_vld), 32'h0);
    check({tag, " timeout"}, 32'(if4.timeout), 32'h0);
    check({tag, " gnt4"},    32'(if4.gnt),     32'h00);
  endtask

  initial begin
    logic [7:0] r;
    logic       e;
    rst_n = 1'b0;
    req_drv = 8'h00;
    en_drv = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    check_all();
    rst_n = 1'b1;

    // Single requester 5 for three cycles.
    drive(8'h20, 1'b1);
    check("single gnt", 32'(if8.gnt), 32'h20);
    check("single id",  32'(if8.gnt_id), 32'd5);
    drive(8'h20, 1'b1);
    drive(8'h20, 1'b1);
    drive(8'h00, 1'b1);
    check("single drop", 32'(if8.gnt), 32'h00);
    drive(8'h00, 1'b1);

    // Full contention.
    for (int i = 0; i < 40; i++) drive(8'hFF, 1'b1);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b1);

    // Pointer wrap: make 7 the last holder, then 0 and 7 compete.
    drive(8'h80, 1'b1);
    drive(8'h00, 1'b1);
    drive(8'h81, 1'b1);
    check("wrap first", 32'(if8.gnt), 32'h01);
    drive(8'h81, 1'b1);
    drive(8'h80, 1'b1);
    drive(8'h80, 1'b1);
    check("wrap next", 32'(if8.gnt), 32'h80);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b1);

    // en drop mid-tenure with holder 3, then 3 and 4 compete.
    drive(8'h08, 1'b1);
    drive(8'h08, 1'b1);
    drive(8'h08, 1'b0);
    check("endrop gnt", 32'(if8.gnt), 32'h00);
    check("endrop to",  32'(if8.timeout), 32'h0);
    drive(8'h18, 1'b1);
    check("endrop next", 32'(if8.gnt), 32'h10);
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b1);

    // Async reset while 2 holds.
    drive(8'h04, 1'b1);
    drive(8'h04, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("async rst");
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    drive(8'h04, 1'b1);
    check("post rst gnt", 32'(if8.gnt), 32'h04);
    drive(8'h00, 1'b1);

    // Lone requester re-granted after every timeout.
    for (int i = 0; i < 10; i++) drive(8'h02, 1'b1);
    drive(8'h00, 1'b1);

    // Randomised traffic.
    r = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0: r = 8'h00;
        1: r = 8'd1 << $urandom_range(0, 7);
        2, 3: r = 8'($urandom);
        default: ;
      endcase
      e = ($urandom_range(0, 15) != 0);
      drive(r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
